// File: rtl/sb_io_ser_if.sv
// sb_io_ser_if: word handshake between a word producer and sb_io_ser.
//   data  : PINS*WORD bits, pin p's lane is data[p*WORD +: WORD]
//   valid : producer offers data
//   ready : consumer takes data on a clock edge where valid & ready
// master = producer side, slave = serializer side.
interface sb_io_ser_if #(
    parameter int PINS = 4,
    parameter int WORD = 8
);
    logic [PINS*WORD-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sb_io_ser.sv
// sb_io_ser: parallel-word to pin serializer for iCE40 registered SB_IO outputs.
// Each word is shifted out MSB-first per pin, 2 bits/clock (DDR) or 1 bit/clock
// (SDR). A shifter plus one holding register let words stream without gaps.
//
// Ports:
//   clock   : single clock, also drives the SB_IO output registers
//   reset   : synchronous, active-high
//   in_if   : slave handshake (data / valid / ready)
//   busy    : shifter holds a word
//   done    : one-cycle pulse on the last beat of each word
//   out_d0  : bit for the rising-edge SB_IO register (D_OUT_0)
//   out_d1  : bit for the falling-edge SB_IO register (D_OUT_1), = out_d0 in SDR
//   pin     : package pins
//
// State table:
//   S_IDLE  | no word in the shifter, pins held at IDLE
//   S_SHIFT | shifter drives beat count_q of the current word

module sb_io_ser #(
    parameter int PINS = 4,
    parameter int WORD = 8,
    parameter bit DDR  = 1'b1,
    parameter bit IDLE = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    sb_io_ser_if.slave      in_if,
    output logic            busy,
    output logic            done,
    output logic [PINS-1:0] out_d0,
    output logic [PINS-1:0] out_d1,
    output logic [PINS-1:0] pin
);

    localparam int BEAT = DDR ? 2 : 1;
    localparam int N    = WORD / BEAT;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int LW   = PINS * WORD;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef SIM_SB_IO
    localparam bit USE_BEHAV = 1'b1;
`elsif SYNTHESIS
    localparam bit USE_BEHAV = 1'b0;
`else
    localparam bit USE_BEHAV = 1'b1;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LW-1:0]   shift_q, shift_d;
    logic [LW-1:0]   hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            last;
    logic            accept;

    assign last        = (state_q == S_SHIFT) && (count_q == CNT_LAST);
    // Ready depends only on registers and reset, never on valid.
    assign in_if.ready = !reset && (!hold_full_q || last);
    assign accept      = in_if.valid && in_if.ready;
    assign busy        = (state_q == S_SHIFT);
    assign done        = last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Data registers need no reset: they are only observed in S_SHIFT.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = in_if.data;
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last) begin
                    count_d = '0;
                    if (hold_full_q) begin
                        shift_d = hold_q;
                        // Hold stays full when it is refilled on the same edge.
                        if (accept) hold_d = in_if.data;
                        else        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shift_d = in_if.data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                    for (int p = 0; p < PINS; p++) begin
                        shift_d[p*WORD +: WORD] = shift_q[p*WORD +: WORD] << BEAT;
                    end
                    if (accept) begin
                        hold_d      = in_if.data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Each lane shifts left, so the current beat is always its top BEAT bits.
    always_comb begin
        out_d0 = {PINS{IDLE}};
        out_d1 = {PINS{IDLE}};
        if (state_q == S_SHIFT) begin
            for (int p = 0; p < PINS; p++) begin
                out_d0[p] = shift_q[p*WORD + WORD - 1];
                out_d1[p] = shift_q[p*WORD + WORD - BEAT];
            end
        end
    end

    if (USE_BEHAV) begin : g_behav
        // Register-accurate model of the SB_IO output path (OUTPUT_ENABLE tied on).
        if (DDR) begin : g_ddr
            logic [PINS-1:0] q0_q, q1_pre_q, q1_q;
            always_ff @(posedge clock) begin
                q0_q     <= out_d0;
                q1_pre_q <= out_d1;
            end
            always_ff @(negedge clock) begin
                q1_q <= q1_pre_q;
            end
            assign pin = clock ? q0_q : q1_q;
        end else begin : g_sdr
            logic [PINS-1:0] q0_q;
            always_ff @(posedge clock) begin
                q0_q <= out_d0;
            end
            assign pin = q0_q;
        end
    end

`ifdef SYNTHESIS
`ifndef SIM_SB_IO
    localparam logic [5:0] PIN_TYPE = DDR ? 6'b0100_01 : 6'b0101_01;
    for (genvar p = 0; p < PINS; p++) begin : g_io
`ifdef SPLIT_INOUTS
        // Pads already split into plain outputs: no input path on the primitive.
        SB_IO #(.PIN_TYPE(PIN_TYPE), .PULLUP(1'b0)) u_io (
            .PACKAGE_PIN   (pin[p]),
            .OUTPUT_CLK    (clock),
            .CLOCK_ENABLE  (1'b1),
            .OUTPUT_ENABLE (1'b1),
            .D_OUT_0       (out_d0[p]),
            .D_OUT_1       (out_d1[p])
        );
`else
        SB_IO #(.PIN_TYPE(PIN_TYPE), .PULLUP(1'b0)) u_io (
            .PACKAGE_PIN   (pin[p]),
            .OUTPUT_CLK    (clock),
            .CLOCK_ENABLE  (1'b1),
            .OUTPUT_ENABLE (1'b1),
            .D_OUT_0       (out_d0[p]),
            .D_OUT_1       (out_d1[p]),
            .D_IN_0        (),
            .D_IN_1        ()
        );
`endif
    end
`endif
`endif

endmodule

// File: tb/tb_sb_io_ser.sv
// Bench for sb_io_ser: three configurations (DDR 2x8, SDR 1x4 with IDLE=1,
// DDR 4x2 i.e. one beat per word), each with a queue-based reference model.
module tb_sb_io_ser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int P = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int W = (g == 0) ? 8 : (g == 1) ? 4 : 2;
        localparam bit D = (g != 1);
        localparam bit I = (g == 1);
        localparam int B = D ? 2 : 1;
        localparam int N = W / B;

        logic           rst;
        logic           valid;
        logic [P*W-1:0] data;
        logic           rdy;
        logic           busy, done;
        logic [P-1:0]   d0, d1, pin;

        sb_io_ser_if #(.PINS(P), .WORD(W)) bus ();
        assign bus.data  = data;
        assign bus.valid = valid;
        assign rdy       = bus.ready;

        sb_io_ser #(.PINS(P), .WORD(W), .DDR(D), .IDLE(I)) dut (
            .clock  (clk),
            .reset  (rst),
            .in_if  (bus),
            .busy   (busy),
            .done   (done),
            .out_d0 (d0),
            .out_d1 (d1),
            .pin    (pin)
        );

        // Model: queue of words owned by the block (head = word being shifted),
        // bi = beat index of the head word.
        logic [P*W-1:0] q[$];
        int             bi = 0;
        bit             known = 1'b0;
        bit             pd_ok = 1'b0;
        logic [P-1:0]   pd0, pd1;

        function automatic logic [P-1:0] exp_bits(input int off);
            logic [P-1:0]   r;
            logic [P*W-1:0] w;
            r = {P{I}};
            if (q.size() > 0) begin
                w = q[0];
                for (int p = 0; p < P; p++) r[p] = w[p*W + W - 1 - B*bi - off];
            end
            return r;
        endfunction

        initial forever begin : model_step
            logic busy_e, last_e, ready_e, acc;
            logic [P-1:0] e0, e1;
            @(posedge clk);
            busy_e  = q.size() > 0;
            last_e  = busy_e && (bi == N - 1);
            ready_e = !rst && (q.size() < 2 || last_e);
            e0 = exp_bits(0);
            e1 = exp_bits(B - 1);
            pd_ok = known;
            pd0 = e0;
            pd1 = e1;
            if (rst) begin
                q.delete();
                bi = 0;
                known = 1'b1;
            end else if (known) begin
                acc = valid && ready_e;
                if (last_e) begin
                    void'(q.pop_front());
                    bi = 0;
                end else if (busy_e) begin
                    bi++;
                end
                if (acc) q.push_back(data);
            end
            #1;
            if (pd_ok) check($sformatf("cfg%0d_pin_hi", g), 32'(pin), 32'(pd0));
            @(negedge clk);
            #1;
            if (known) begin
                busy_e  = q.size() > 0;
                last_e  = busy_e && (bi == N - 1);
                ready_e = !rst && (q.size() < 2 || last_e);
                check($sformatf("cfg%0d_busy", g), 32'(busy), 32'(busy_e));
                check($sformatf("cfg%0d_done", g), 32'(done), 32'(last_e));
                check($sformatf("cfg%0d_ready", g), 32'(rdy), 32'(ready_e));
                check($sformatf("cfg%0d_d0", g), 32'(d0), 32'(exp_bits(0)));
                check($sformatf("cfg%0d_d1", g), 32'(d1), 32'(exp_bits(B - 1)));
            end
            if (pd_ok) check($sformatf("cfg%0d_pin_lo", g), 32'(pin), 32'(pd1));
        end
    end

    // {ready, busy, done} at [18:16], d1 at [15:8], d0 at [7:0]
    function automatic logic [31:0] peek(input int k);
        case (k)
            0: return {13'd0, g_cfg[0].rdy, g_cfg[0].busy, g_cfg[0].done,
                       8'(g_cfg[0].d1), 8'(g_cfg[0].d0)};
            1: return {13'd0, g_cfg[1].rdy, g_cfg[1].busy, g_cfg[1].done,
                       8'(g_cfg[1].d1), 8'(g_cfg[1].d0)};
            default: return {13'd0, g_cfg[2].rdy, g_cfg[2].busy, g_cfg[2].done,
                       8'(g_cfg[2].d1), 8'(g_cfg[2].d0)};
        endcase
    endfunction

    task automatic drive(input int k, input logic r, input logic v, input logic [31:0] dat);
        case (k)
            0: begin g_cfg[0].rst = r; g_cfg[0].valid = v; g_cfg[0].data = dat[15:0]; end
            1: begin g_cfg[1].rst = r; g_cfg[1].valid = v; g_cfg[1].data = dat[3:0];  end
            default: begin g_cfg[2].rst = r; g_cfg[2].valid = v; g_cfg[2].data = dat[7:0]; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    task automatic stream(input int k, input int nwords, input int prob);
        logic [31:0] s, dat;
        logic        v, r;
        int          acc, c;
        acc = 0; c = 0; v = 1'b0; r = 1'b0; dat = '0;
        while (acc < nwords && c < 4000) begin
            if (!v || r) begin
                v   = ($urandom_range(99) < prob);
                dat = $urandom;
            end
            drive(k, 1'b0, v, dat);
            half();
            s = peek(k);
            r = s[18];
            if (k == 2 && prob == 100 && c > 0) begin
                check("n1_ready_const", 32'(s[18]), 32'd1);
                check("n1_done_const", 32'(s[16]), 32'd1);
            end
            tick();
            if (v && r) acc++;
            c++;
        end
        check($sformatf("stream%0d_words", k), 32'(acc), 32'(nwords));
        drive(k, 1'b0, 1'b0, '0);
        repeat (12) tick();
    endtask

    initial begin
        logic [31:0] s;
        logic        r;
        int          wi;
        int          a_d0 [4] = '{2, 3, 1, 0};
        int          a_d1 [4] = '{0, 1, 3, 2};
        int          r_exp [5] = '{1, 1, 0, 0, 1};
        int          sdr_bits [4] = '{1, 0, 0, 1};
        logic [15:0] words [3] = '{16'h1234, 16'hBEEF, 16'h0F5A};

        for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b0, '0);
        repeat (3) tick();

        // Reset values
        half();
        s = peek(0);
        check("rst_ready", 32'(s[18]), 32'd0);
        check("rst_busy", 32'(s[17]), 32'd0);
        check("rst_done", 32'(s[16]), 32'd0);
        check("rst_d0", 32'(s[7:0]), 32'd0);
        s = peek(1);
        check("rst_idle1_d0", 32'(s[7:0]), 32'd1);
        check("rst_idle1_d1", 32'(s[15:8]), 32'd1);
        check("rst_idle1_pin", 32'(g_cfg[1].pin), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, '0);
        half();
        s = peek(0);
        check("post_rst_ready", 32'(s[18]), 32'd1);

        // Single DDR word 16'hA53C
        tick();
        drive(0, 1'b0, 1'b1, 32'hA53C);
        tick();
        drive(0, 1'b0, 1'b0, '0);
        for (int b = 0; b < 4; b++) begin
            half();
            s = peek(0);
            check($sformatf("a53c_d0_b%0d", b), 32'(s[7:0]), 32'(a_d0[b]));
            check($sformatf("a53c_d1_b%0d", b), 32'(s[15:8]), 32'(a_d1[b]));
            check($sformatf("a53c_done_b%0d", b), 32'(s[16]), 32'(b == 3));
        end
        half();
        s = peek(0);
        check("a53c_idle_busy", 32'(s[17]), 32'd0);
        check("a53c_idle_d", 32'(s[15:0]), 32'd0);

        // Back-to-back: three words, valid held high
        tick();
        wi = 0;
        drive(0, 1'b0, 1'b1, 32'(words[0]));
        for (int c = 0; c < 13; c++) begin
            half();
            s = peek(0);
            if (c < 5) check($sformatf("b2b_ready_c%0d", c), 32'(s[18]), 32'(r_exp[c]));
            check($sformatf("b2b_busy_c%0d", c), 32'(s[17]), 32'(c >= 1));
            check($sformatf("b2b_done_c%0d", c), 32'(s[16]), 32'(c == 4 || c == 8 || c == 12));
            r = s[18];
            tick();
            if (r && wi < 3) begin
                wi++;
                if (wi < 3) drive(0, 1'b0, 1'b1, 32'(words[wi]));
                else        drive(0, 1'b0, 1'b0, '0);
            end
        end
        half();
        s = peek(0);
        check("b2b_end_busy", 32'(s[17]), 32'd0);

        // SDR word 4'b1001
        tick();
        drive(1, 1'b0, 1'b1, 32'h9);
        tick();
        drive(1, 1'b0, 1'b0, '0);
        for (int b = 0; b < 4; b++) begin
            half();
            s = peek(1);
            check($sformatf("sdr_d0_b%0d", b), 32'(s[7:0]), 32'(sdr_bits[b]));
            check($sformatf("sdr_d1_b%0d", b), 32'(s[15:8]), 32'(sdr_bits[b]));
            check($sformatf("sdr_done_b%0d", b), 32'(s[16]), 32'(b == 3));
        end
        half();
        s = peek(1);
        check("sdr_idle_busy", 32'(s[17]), 32'd0);

        // Reset on beat 2 with hold full (IDLE=1)
        tick();
        drive(1, 1'b0, 1'b1, 32'hA);
        tick();
        drive(1, 1'b0, 1'b1, 32'h5);
        tick();
        drive(1, 1'b0, 1'b0, '0);
        tick();
        drive(1, 1'b1, 1'b0, '0);
        half();
        s = peek(1);
        check("mrst_ready_in_reset", 32'(s[18]), 32'd0);
        check("mrst_beat2_d0", 32'(s[7:0]), 32'd1);
        check("mrst_beat2_busy", 32'(s[17]), 32'd1);
        tick();
        drive(1, 1'b0, 1'b0, '0);
        half();
        s = peek(1);
        check("mrst_busy", 32'(s[17]), 32'd0);
        check("mrst_done", 32'(s[16]), 32'd0);
        check("mrst_d0", 32'(s[7:0]), 32'd1);
        check("mrst_d1", 32'(s[15:8]), 32'd1);
        check("mrst_ready_after", 32'(s[18]), 32'd1);
        tick();
        drive(1, 1'b0, 1'b1, 32'h7);
        tick();
        drive(1, 1'b0, 1'b0, '0);
        half();
        s = peek(1);
        check("mrst_next_b0_d0", 32'(s[7:0]), 32'd0);
        check("mrst_next_b0_busy", 32'(s[17]), 32'd1);
        half();
        half();
        half();
        s = peek(1);
        check("mrst_next_b3_done", 32'(s[16]), 32'd1);

        // Random streams against the models
        stream(0, 100, 75);
        stream(0, 60, 100);
        stream(1, 30, 60);
        stream(2, 40, 100);
        stream(2, 30, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_io_ser.md
# sb_io_ser

Parametrised iCE40 output serializer. Accepts parallel words over a valid/ready handshake and shifts them MSB-first onto `PINS` package pins, using one registered `SB_IO` per pin in DDR (2 bits/clock) or SDR (1 bit/clock) mode. Sits between a word-producing unit (QSPI/flash command engine, video/TMDS lane, LED/parallel bus driver) and the physical pins. Provides a 2-entry buffer (shifter + holding register) so back-to-back words stream without gaps.

## Interface
- `PINS`, 4: number of output pins (≥1).
- `WORD`, 8: bits per pin per word. Must be even when `DDR=1`; ≥1.
- `DDR`, 1: 1 selects DDR (`PIN_TYPE 6'b0100_01`, 2 bits/clock); 0 selects SDR (`PIN_TYPE 6'b0101_01`, 1 bit/clock).
- `IDLE`, 0: level driven on every pin while no word is shifting.

Ports:
- `clock` in 1: single clock, also `SB_IO` `OUTPUT_CLK`.
- `reset` in 1: synchronous, active-high.
- `in_data` in `PINS*WORD`: pin p's lane is `in_data[p*WORD +: WORD]`.
- `in_valid` in 1: word offered.
- `in_ready` out 1: word accepted on a clock edge where `in_valid & in_ready`.
- `busy` out 1: shifter holds a word.
- `done` out 1: one-cycle pulse on the last beat of each word.
- `out_d0` out `PINS`: value presented to `D_OUT_0` (rising-edge bit).
- `out_d1` out `PINS`: value presented to `D_OUT_1` (falling-edge bit). Equals `out_d0` when `DDR=0`.
- `pin` out `PINS`: package pins. `SB_IO` primitive selection honours `SIM_SB_IO` and `SPLIT_INOUTS`; `OUTPUT_ENABLE` is tied to 1.

## Operation
- Beat: B = `DDR ? 2 : 1` bits per pin per clock. Beats per word N = `WORD/B`. Beat counter width is clog2(N), minimum 1.
- Per pin, DDR beat k drives `d0` = lane bit `WORD-1-2k` and `d1` = lane bit `WORD-2-2k`. SDR beat k drives `d0` = `d1` = lane bit `WORD-1-k`.
- State machine:
  - IDLE: `out_d0` = `out_d1` = {PINS{IDLE}}; `busy` = 0.
  - SHIFT: current beat is driven; the counter counts 0..N-1. `last` = SHIFT & count==N-1.
- `in_ready` = !reset & (!hold_full | last). This is combinational from registers only, with no path from `in_valid`.
- On an accept edge:
  - Shifter is IDLE, or `last` with hold empty: the word loads straight into the shifter (count=0, SHIFT).
  - Otherwise: the word goes to hold.
- On a `last` edge:
  - If hold is full, hold moves to the shifter (count=0) and hold is refilled if an accept happens on the same edge.
  - If hold is empty and there is no accept, the block goes to IDLE.
- `done` = `last` (combinational from registers).
- Reset: state IDLE, hold empty, counter 0. Mid-word reset discards the shifter and hold contents without emitting `done`.

## Timing
- Reset values: `in_ready`=0 while `reset`=1 and 1 on the first cycle after; `busy`=0; `done`=0; `out_d0`=`out_d1`={PINS{IDLE}}; `pin`=IDLE after the first post-reset `SB_IO` edge.
- Latency:
  - A word accepted at edge E into an idle shifter shows beat 0 on `out_d*` after E, and on `pin` after E+1.
  - DDR: `d0` appears during the high phase and `d1` during the low phase of the following cycle.
- Throughput:
  - With `in_valid` held high, consecutive words occupy contiguous beats with zero idle cycles.
  - This holds for all N ≥ 1, including N=1, where a shifter load and an accept happen every cycle.
- Simultaneous `last`, hold full and accept: hold moves to the shifter, the new word moves to hold, and `in_ready` stays 1.
- Backpressure: `in_ready`=0 exactly when hold is full and the shifter is not on its last beat.

## Test plan
- Single DDR word (PINS=2, WORD=8, DDR=1), `in_data`=16'hA53C accepted from idle:
  - `out_d0`/`out_d1` per beat = 10/00, 11/01, 01/11, 00/10.
  - `done` high on beat 3 only, then IDLE=0 on both.
  - `pin` trails `out_d*` by 1 cycle.
- Back-to-back: three words with `in_valid` held high → 12 contiguous beats, `done` on beats 3, 7, 11, `busy` continuously 1. `in_ready` sequence: 1, 1, 0, 0, 1, ….
- Backpressure: `in_valid` held high with the consumer at full rate → no word is lost or duplicated. A scoreboard compares 100 random words against the serialised `out_d*`.
- SDR mode (DDR=0, WORD=4, PINS=1), word 4'b1001 → `out_d0`=`out_d1` = 1, 0, 0, 1 over 4 cycles; `done` on the 4th.
- N=1 (DDR=1, WORD=2, PINS=4), continuous random stream → one word per cycle, `in_ready` constantly 1, `done` constantly 1.
- Reset asserted on beat 2 of a word with hold full → next cycle `busy`=0, `out_d*`={PINS{IDLE}} (run with IDLE=1), no `done`, `in_ready`=0 during reset and 1 after. The next accepted word starts at beat 0.
